// File: rtl/tdm_output.sv
// tdm_output: TDM transmit serializer.
// Sample pairs enter a small FIFO through valid/ready. One 64-bit frame
// {ch1,16'h0,ch2,16'h0} is shifted out MSB first per 256-mclk period, one bit
// every 4 mclk. Bits change only where cnt256_n[1:0]==0, so each bit is stable
// when the receiver samples it at cnt256_n[1:0]==2.
module tdm_output #(
  parameter int DEPTH         = 4,
  parameter bit UNDERRUN_ZERO = 1'b1
) (
  input  logic                     mclk,
  input  logic                     rst_n,
  input  logic [7:0]               cnt256_n,
  input  logic [15:0]              in_ch1,
  input  logic [15:0]              in_ch2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     tx_en,
  output logic                     tdm_out,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_L  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic [31:0]   last_q;
  logic [63:0]   sh_q;
  logic          und_q;

  logic        frame_start, bit_edge, empty, push;
  logic        pop, load, set_und;
  logic [31:0] head, src_pair;
  logic [63:0] load_frame;

  assign frame_start = (cnt256_n == 8'd0);
  assign bit_edge    = (cnt256_n[1:0] == 2'd0);
  assign empty       = (lvl_q == '0);
  assign in_ready    = (lvl_q != FULL_L);
  assign push        = in_valid & in_ready;
  assign head        = mem_q[rd_q];

  // On underrun the pair sent is either silence or the last popped pair
  assign src_pair   = pop ? head : (UNDERRUN_ZERO ? 32'd0 : last_q);
  assign load_frame = {src_pair[31:16], 16'h0, src_pair[15:0], 16'h0};

  assign tdm_out    = sh_q[63];
  assign underrun   = und_q;
  assign fifo_level = lvl_q;

  // State register
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus frame-start decisions (pop / load / underrun)
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    set_und = 1'b0;
    unique case (state_q)
      S_IDLE: if (tx_en) state_d = S_WAIT;
      S_WAIT: begin
        if (frame_start) begin
          if (!tx_en) state_d = S_IDLE;
          else if (!empty) begin
            state_d = S_RUN;
            pop     = 1'b1;
            load    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (frame_start) begin
          if (!tx_en) state_d = S_IDLE;
          else begin
            load    = 1'b1;
            pop     = !empty;
            set_und = empty;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage; no reset needed, validity tracked by the level counter
  always_ff @(posedge mclk) begin
    if (push) mem_q[wr_q] <= {in_ch1, in_ch2};
  end

  // FIFO pointers and level; pop reads the head as it was before this edge
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + ONE_P;
      if (pop)  rd_q <= rd_q + ONE_P;
      unique case ({push, pop})
        2'b10:   lvl_q <= lvl_q + ONE_L;
        2'b01:   lvl_q <= lvl_q - ONE_L;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  // Output shift register; its MSB is the line, cleared whenever not running
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      last_q <= '0;
    end else begin
      if (pop) last_q <= head;
      if (load)
        sh_q <= load_frame;
      else if (bit_edge)
        sh_q <= (state_q == S_RUN && state_d == S_RUN) ? {sh_q[62:0], 1'b0} : '0;
    end
  end

  // Sticky underrun flag; a new underrun beats a same-cycle clear
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)            und_q <= 1'b0;
    else if (set_und)      und_q <= 1'b1;
    else if (underrun_clr) und_q <= 1'b0;
  end

endmodule

// File: tb/tb_tdm_output.sv
// Bench for tdm_output: two instances (zero-fill and repeat-last underrun)
// share stimulus and are compared every cycle with a frame-level model.
module tb_tdm_output;
  localparam int DEPTH = 4;
  localparam int MI = 0, MW = 1, MR = 2;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [7:0]  cnt;
  logic [15:0] ch1, ch2;
  logic        valid, tx_en, clr;
  logic        rdy0, rdy1, tdo0, tdo1, und0, und1;
  logic [2:0]  lvl0, lvl1;

  always #5 mclk = ~mclk;

  tdm_output #(.DEPTH(DEPTH), .UNDERRUN_ZERO(1'b1)) u_zero (
    .mclk(mclk), .rst_n(rst_n), .cnt256_n(cnt), .in_ch1(ch1), .in_ch2(ch2),
    .in_valid(valid), .in_ready(rdy0), .tx_en(tx_en), .tdm_out(tdo0),
    .underrun(und0), .underrun_clr(clr), .fifo_level(lvl0));

  tdm_output #(.DEPTH(DEPTH), .UNDERRUN_ZERO(1'b0)) u_rep (
    .mclk(mclk), .rst_n(rst_n), .cnt256_n(cnt), .in_ch1(ch1), .in_ch2(ch2),
    .in_valid(valid), .in_ready(rdy1), .tx_en(tx_en), .tdm_out(tdo1),
    .underrun(und1), .underrun_clr(clr), .fifo_level(lvl1));

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fw(input logic [31:0] p);
    return {p[31:16], 16'h0, p[15:0], 16'h0};
  endfunction

  // Reference model: a queue of pairs, a frame word per instance and the
  // expected line value picked by bit index from that word.
  logic [31:0] q[$];
  int          mode;
  logic [31:0] mframe[2];
  logic [31:0] mlast;
  logic        m_und, m_push, und_set;
  logic        m_out[2];
  logic [31:0] hd;
  logic [63:0] w;
  logic [63:0] rxs0, rxs1, rxw0, rxw1;

  task automatic model_reset();
    q.delete();
    mode = MI; mlast = '0; m_und = 1'b0;
    mframe[0] = '0; mframe[1] = '0;
    m_out[0] = 1'b0; m_out[1] = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) model_reset();
    else begin
      m_push  = valid && (q.size() < DEPTH);
      und_set = 1'b0;
      if (mode == MI) begin
        if (tx_en) mode = MW;
      end else if (cnt == 8'd0) begin
        if (!tx_en) mode = MI;
        else if (q.size() != 0) begin
          hd = q.pop_front();
          mlast = hd; mframe[0] = hd; mframe[1] = hd;
          mode = MR;
        end else if (mode == MR) begin
          und_set = 1'b1;
          mframe[0] = '0;
          mframe[1] = mlast;
        end
      end
      if (m_push) q.push_back({ch1, ch2});
      if (und_set) m_und = 1'b1;
      else if (clr) m_und = 1'b0;
      if (cnt[1:0] == 2'd0) begin
        for (int i = 0; i < 2; i++) begin
          w = fw(mframe[i]);
          m_out[i] = (mode == MR) ? w[63 - int'(cnt[7:2])] : 1'b0;
        end
      end
    end
  endtask

  // One clock: model at posedge, receiver-style capture, checks at negedge
  task automatic cyc();
    @(posedge mclk);
    model_step();
    if (cnt[1:0] == 2'd2) begin
      rxs0 = {rxs0[62:0], tdo0};
      rxs1 = {rxs1[62:0], tdo1};
    end
    if (cnt == 8'd255) begin
      rxw0 = rxs0;
      rxw1 = rxs1;
    end
    @(negedge mclk);
    chk("tdm_zero", 64'(tdo0), 64'(m_out[0]));
    chk("tdm_rep",  64'(tdo1), 64'(m_out[1]));
    chk("lvl_zero", 64'(lvl0), 64'(q.size()));
    chk("lvl_rep",  64'(lvl1), 64'(q.size()));
    chk("rdy_zero", 64'(rdy0), 64'(q.size() < DEPTH));
    chk("rdy_rep",  64'(rdy1), 64'(q.size() < DEPTH));
    chk("und_zero", 64'(und0), 64'(m_und));
    chk("und_rep",  64'(und1), 64'(m_und));
    cnt = cnt + 8'd1;
  endtask

  // Advance at least one cycle until cnt==c is presented for the next edge
  task automatic goto(input logic [7:0] c);
    do cyc(); while (cnt != c);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    ch1 = a; ch2 = b; valid = 1'b1;
    cyc();
    valid = 1'b0;
  endtask

  logic [31:0] p[4];
  int          rate;

  initial begin
    rst_n = 1'b0; cnt = 8'd200; ch1 = '0; ch2 = '0;
    valid = 1'b0; tx_en = 1'b0; clr = 1'b0;
    rxs0 = '0; rxs1 = '0; rxw0 = '0; rxw1 = '0;
    model_reset();
    repeat (3) cyc();
    chk("rst_tdm", 64'(tdo0), 64'd0);
    chk("rst_rdy", 64'(rdy0), 64'd1);
    chk("rst_lvl", 64'(lvl0), 64'd0);
    chk("rst_und", 64'(und0), 64'd0);
    rst_n = 1'b1;

    // Single pair framed MSB first; tx_en dropped at cnt=100 mid-frame
    goto(8'd20);
    push(16'hA5C3, 16'h0F0F);
    tx_en = 1'b1;
    goto(8'd0);
    goto(8'd100);
    tx_en = 1'b0;
    goto(8'd0);
    chk("t1_frame_zero", rxw0, 64'hA5C3_0000_0F0F_0000);
    chk("t1_frame_rep",  rxw1, 64'hA5C3_0000_0F0F_0000);
    cyc();
    chk("t4_tdm_idle", 64'(tdo0), 64'd0);
    chk("t4_no_und",   64'(und0), 64'd0);
    goto(8'd0);
    chk("t4_idle_frame", rxw0, 64'd0);

    // Fill to DEPTH while idle, refuse one more, then drain
    goto(8'd10);
    for (int i = 0; i < 4; i++) begin
      p[i] = $urandom();
      push(p[i][31:16], p[i][15:0]);
    end
    chk("t2_full_lvl", 64'(lvl0), 64'd4);
    chk("t2_full_rdy", 64'(rdy0), 64'd0);
    push(16'hDEAD, 16'hBEEF);
    chk("t2_refused", 64'(lvl0), 64'd4);
    tx_en = 1'b1;
    goto(8'd0);
    cyc();
    chk("t2_lvl_after_pop", 64'(lvl0), 64'd3);
    chk("t2_rdy_after_pop", 64'(rdy0), 64'd1);
    goto(8'd0);
    chk("t2_frame0", rxw0, fw(p[0]));
    for (int i = 1; i < 4; i++) begin
      goto(8'd0);
      chk("t2_frame", rxw0, fw(p[i]));
    end

    // Underrun: zero frame vs repeated last frame, then clear
    goto(8'd0);
    chk("t3_zero_frame", rxw0, 64'd0);
    chk("t3_rep_frame",  rxw1, fw(p[3]));
    chk("t3_und", 64'(und0), 64'd1);
    goto(8'd50);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t3_clr", 64'(und0), 64'd0);

    // Push on the frame-start edge into an empty FIFO, with a clear: underrun wins
    goto(8'd0);
    clr = 1'b1;
    push(16'h1234, 16'h5678);
    clr = 1'b0;
    chk("t5_und", 64'(und0), 64'd1);
    chk("t5_lvl", 64'(lvl0), 64'd1);
    goto(8'd0);
    chk("t5_gap_frame", rxw0, 64'd0);
    goto(8'd0);
    chk("t5_late_frame", rxw0, fw(32'h1234_5678));

    // Randomised traffic, rates, clears and tx_en toggles
    for (int f = 0; f < 30; f++) begin
      case ($urandom_range(0, 2))
        0:       rate = 60;
        1:       rate = 200;
        default: rate = 600;
      endcase
      for (int c = 0; c < 256; c++) begin
        valid = ($urandom_range(0, rate) == 0);
        ch1 = 16'($urandom());
        ch2 = 16'($urandom());
        clr = ($urandom_range(0, 499) == 0);
        if (cnt == 8'd100 && $urandom_range(0, 7) == 0) tx_en = ~tx_en;
        cyc();
      end
    end
    valid = 1'b0; clr = 1'b0;

    // Asynchronous reset in the middle of a frame
    tx_en = 1'b1;
    push(16'hFFFF, 16'hFFFF);
    push(16'hFFFF, 16'hFFFF);
    goto(8'd0);
    goto(8'd130);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_tdm_async", 64'(tdo0), 64'd0);
    chk("t6_lvl_async", 64'(lvl0), 64'd0);
    chk("t6_und_async", 64'(und0), 64'd0);
    chk("t6_tdm_async_rep", 64'(tdo1), 64'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    goto(8'd20);
    push(16'h8001, 16'h7FFE);
    goto(8'd0);
    goto(8'd0);
    chk("t6_restart_frame", rxw0, fw(32'h8001_7FFE));
    chk("t6_restart_rep",   rxw1, fw(32'h8001_7FFE));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
